gtf_example_reset_seq: RTL

- Responder to the example-design init state machine.
- Accepts its reset_all and reset_rx requests and sequences GTF PLL, TX datapath and RX datapath resets in the free-running clock domain.
- Generates the tx_init_done/rx_init_done indications that the init state machine monitors.
- Sits between the init state machine and the GTF wizard reset inputs/status outputs.

---
 rtl/gtf_example_reset_seq.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/gtf_example_reset_seq.sv
// Sequences GTF PLL/TX/RX resets for the init state machine and reports tx/rx init done.
// Optional macro RESET_SEQ_LOCK_MON_EN: lock loss after PLL wait restarts the full sequence.
module gtf_example_reset_seq #(
  parameter int P_FREERUN_FREQUENCY = 200,
  parameter int P_RST_PULSE_CYC     = 16,
  parameter int P_LOCK_SETTLE_CYC   = 256,
  parameter int P_LOCK_TIMEOUT_US   = 1000,
  parameter int P_DONE_TIMEOUT_US   = 2000
) (
  input  logic       clk_freerun_in,
  input  logic       reset_n_in,
  input  logic       reset_all_in,
  input  logic       reset_rx_in,
  input  logic       plllock_in,
  input  logic       tx_resetdone_in,
  input  logic       rx_resetdone_in,
  output logic       pll_reset_out,
  output logic       tx_reset_out,
  output logic       rx_reset_out,
  output logic       tx_init_done_out,
  output logic       rx_init_done_out,
  output logic [3:0] timeout_ctr_out,
  output logic [2:0] state_out
);

  localparam logic [63:0] LOCK_TC    = 64'(P_LOCK_TIMEOUT_US) * 64'(P_FREERUN_FREQUENCY);
  localparam logic [63:0] DONE_TC    = 64'(P_DONE_TIMEOUT_US) * 64'(P_FREERUN_FREQUENCY);
  localparam logic [23:0] LOCK_TC_M1 = LOCK_TC[23:0] - 24'd1;
  localparam logic [23:0] DONE_TC_M1 = DONE_TC[23:0] - 24'd1;
  localparam logic [7:0]  PULSE_M1   = 8'(P_RST_PULSE_CYC - 1);
  localparam logic [15:0] SETTLE_M1  = 16'(P_LOCK_SETTLE_CYC - 1);

  generate
    if (LOCK_TC > 64'h0000_0000_00FF_FFFF || DONE_TC > 64'h0000_0000_00FF_FFFF ||
        LOCK_TC == 64'd0 || DONE_TC == 64'd0) begin : g_tc_range_err
      $error("timeout terminal count does not fit the 24-bit timer");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLL_RST  = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_RX_RST   = 3'd4,
    ST_RX_WAIT  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t      state_q;
  logic [2:0]  lock_sync_q;
  logic [2:0]  txd_sync_q;
  logic [2:0]  rxd_sync_q;
  logic        all_prev_q;
  logic        rx_prev_q;
  logic [23:0] timer_q;
  logic [7:0]  pulse_q;
  logic [15:0] settle_q;
  logic [3:0]  tmo_q;
  logic        pll_rst_q;
  logic        tx_rst_q;
  logic        rx_rst_q;
  logic        tx_done_q;
  logic        rx_done_q;

  logic lock_sync;
  logic txd_sync;
  logic rxd_sync;
  logic all_rise;
  logic rx_rise;
  logic lock_lost;
  logic in_wait;

  always_ff @(posedge clk_freerun_in) begin
    if (!reset_n_in) begin
      lock_sync_q <= 3'b000;
      txd_sync_q  <= 3'b000;
      rxd_sync_q  <= 3'b000;
      all_prev_q  <= 1'b0;
      rx_prev_q   <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[1:0], plllock_in};
      txd_sync_q  <= {txd_sync_q[1:0], tx_resetdone_in};
      rxd_sync_q  <= {rxd_sync_q[1:0], rx_resetdone_in};
      all_prev_q  <= reset_all_in;
      rx_prev_q   <= reset_rx_in;
    end
  end

  assign lock_sync = lock_sync_q[2];
  assign txd_sync  = txd_sync_q[2];
  assign rxd_sync  = rxd_sync_q[2];
  assign all_rise  = reset_all_in & ~all_prev_q;
  assign rx_rise   = reset_rx_in & ~rx_prev_q;
  assign in_wait   = (state_q == ST_PLL_WAIT) || (state_q == ST_TX_WAIT) ||
                     (state_q == ST_RX_WAIT);

`ifdef RESET_SEQ_LOCK_MON_EN
  assign lock_lost = !lock_sync && ((state_q == ST_TX_WAIT) || (state_q == ST_RX_RST) ||
                                    (state_q == ST_RX_WAIT) || (state_q == ST_DONE));
`else
  assign lock_lost = 1'b0;
`endif

  always_ff @(posedge clk_freerun_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_IDLE;
      pll_rst_q <= 1'b1;
      tx_rst_q  <= 1'b1;
      rx_rst_q  <= 1'b1;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      tmo_q     <= 4'd0;
      timer_q   <= 24'd0;
      pulse_q   <= 8'd0;
      settle_q  <= 16'd0;
    end else begin
      if (in_wait) timer_q <= timer_q + 24'd1;

      // Full restart: request edge, leaving idle, or (optionally) lock loss; never counts as timeout
      if (all_rise || state_q == ST_IDLE || lock_lost) begin
        state_q   <= ST_PLL_RST;
        pll_rst_q <= 1'b1;
        tx_rst_q  <= 1'b1;
        rx_rst_q  <= 1'b1;
        tx_done_q <= 1'b0;
        rx_done_q <= 1'b0;
        pulse_q   <= 8'd0;
        timer_q   <= 24'd0;
      end else begin
        case (state_q)
          ST_PLL_RST: begin
            if (pulse_q == PULSE_M1) begin
              state_q   <= ST_PLL_WAIT;
              pll_rst_q <= 1'b0;
              timer_q   <= 24'd0;
              settle_q  <= 16'd0;
            end else begin
              pulse_q <= pulse_q + 8'd1;
            end
          end
          ST_PLL_WAIT: begin
            if (timer_q == LOCK_TC_M1) begin
              state_q   <= ST_PLL_RST;
              pll_rst_q <= 1'b1;
              pulse_q   <= 8'd0;
              timer_q   <= 24'd0;
              if (tmo_q != 4'hF) tmo_q <= tmo_q + 4'd1;
            end else if (lock_sync) begin
              if (settle_q == SETTLE_M1) begin
                state_q  <= ST_TX_WAIT;
                tx_rst_q <= 1'b0;
                timer_q  <= 24'd0;
              end else begin
                settle_q <= settle_q + 16'd1;
              end
            end else begin
              settle_q <= 16'd0;
            end
          end
          ST_TX_WAIT: begin
            if (timer_q == DONE_TC_M1) begin
              state_q   <= ST_PLL_RST;
              pll_rst_q <= 1'b1;
              tx_rst_q  <= 1'b1;
              pulse_q   <= 8'd0;
              timer_q   <= 24'd0;
              if (tmo_q != 4'hF) tmo_q <= tmo_q + 4'd1;
            end else if (txd_sync) begin
              state_q   <= ST_RX_WAIT;
              tx_done_q <= 1'b1;
              rx_rst_q  <= 1'b0;
              timer_q   <= 24'd0;
            end
          end
          ST_RX_RST: begin
            if (rx_rise) begin
              pulse_q <= 8'd0;
            end else if (pulse_q == PULSE_M1) begin
              state_q  <= ST_RX_WAIT;
              rx_rst_q <= 1'b0;
              timer_q  <= 24'd0;
            end else begin
              pulse_q <= pulse_q + 8'd1;
            end
          end
          ST_RX_WAIT: begin
            if (timer_q == DONE_TC_M1 || rx_rise) begin
              state_q   <= ST_RX_RST;
              rx_rst_q  <= 1'b1;
              rx_done_q <= 1'b0;
              pulse_q   <= 8'd0;
              timer_q   <= 24'd0;
              if (!rx_rise && tmo_q != 4'hF) tmo_q <= tmo_q + 4'd1;
            end else if (rxd_sync) begin
              state_q   <= ST_DONE;
              rx_done_q <= 1'b1;
            end
          end
          ST_DONE: begin
            // Resetdone loss here is left to the init state machine
            if (rx_rise) begin
              state_q   <= ST_RX_RST;
              rx_rst_q  <= 1'b1;
              rx_done_q <= 1'b0;
              pulse_q   <= 8'd0;
            end
          end
          default: begin
            state_q   <= ST_PLL_RST;
            pll_rst_q <= 1'b1;
            tx_rst_q  <= 1'b1;
            rx_rst_q  <= 1'b1;
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            pulse_q   <= 8'd0;
            timer_q   <= 24'd0;
          end
        endcase
      end
    end
  end

  assign pll_reset_out    = pll_rst_q;
  assign tx_reset_out     = tx_rst_q;
  assign rx_reset_out     = rx_rst_q;
  assign tx_init_done_out = tx_done_q;
  assign rx_init_done_out = rx_done_q;
  assign timeout_ctr_out  = tmo_q;
  assign state_out        = state_q;

endmodule
